// File: rtl/serial_parity_rx.sv
`default_nettype none
// ============================================================================
// Module      : serial_parity_rx
// Description : Strobed serial receiver for start/data/parity/stop frames,
//               reporting the data word with parity and framing status.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_parity_rx #(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_q, par_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;

    logic                w_par_x;
    logic                w_ok;

    assign w_par_x = (^shift_q) ^ par_q;
    assign w_ok    = (PARITY_ODD != 0) ? w_par_x : ~w_par_x;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    // Status flags default low every cycle so the pulse stays one clk wide
    // no matter how sparse bit_en is.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        if (bit_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_in) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end
                end
                S_DATA: begin
                    shift_d           = shift_q >> 1;
                    shift_d[DATA_W-1] = rx_in;
                    if (cnt_q == c_last_bit) begin
                        state_d = S_PARITY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    par_d   = rx_in;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    perr_d  = ~w_ok;
                    ferr_d  = ~rx_in;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;

endmodule
`default_nettype wire

// File: doc/serial_parity_rx.md
SERIAL_PARITY_RX -- requirements
Module: serial_parity_rx

Interface
REQ-001 The block SHALL have a parameter DATA_W, default 8, giving the data bits per frame (legal range 1..16).
REQ-002 The block SHALL have a parameter PARITY_ODD, default 0, where 0 selects even parity and 1 selects odd parity.
REQ-003 The block SHALL have one clock and an asynchronous active-high reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-004 The block SHALL have the port bit_en  input  1  bit-sample strobe; rx_in is sampled only on clk edges where bit_en=1.
REQ-005 The block SHALL have the port rx_in  input  1  serial line, idle high.
REQ-006 The block SHALL have the port data_out  output  DATA_W  last received data word, LSB first on the line.
REQ-007 The block SHALL have the port valid  output  1  one-cycle pulse marking frame completion.
REQ-008 The block SHALL have the port parity_err  output  1  parity mismatch on the completed frame; qualified by valid.
REQ-009 The block SHALL have the port frame_err  output  1  stop bit sampled low on the completed frame; qualified by valid.

Function
REQ-010 The line frame format SHALL be: 1 start bit (0), DATA_W data bits LSB first, 1 parity bit, 1 stop bit (1). This is the receive end of the parity-generating serial transmitter.
REQ-011 The FSM SHALL have the states IDLE, DATA, PARITY and STOP, with all transitions occurring only on bit_en=1 cycles.
REQ-012 IDLE SHALL move to DATA on a sample of rx_in=0, which is the start bit; a sample of 1 keeps the FSM in IDLE.
REQ-013 DATA SHALL shift in exactly DATA_W samples, the first sample landing in bit 0, using a bit counter wide enough for DATA_W; it SHALL move to PARITY after sample DATA_W.
REQ-014 PARITY SHALL capture one sample as p and then move to STOP.
REQ-015 STOP SHALL capture one sample as s and then return to IDLE.
REQ-016 The parity check SHALL be ok = ~(^data ^ p) (XNOR reduction) when PARITY_ODD=0, and ok = (^data ^ p) when PARITY_ODD=1; parity_err = ~ok.
REQ-017 On the clk edge that samples the stop bit: data_out SHALL load the shifted word, and valid, parity_err and frame_err (= ~s) SHALL be registered so that they are visible for exactly the following cycle.
REQ-018 valid SHALL be exactly one clk cycle wide regardless of the bit_en rate. When bit_en is held at 1 continuously, the next frame's start bit may be sampled in that same valid cycle.
REQ-019 parity_err and frame_err SHALL be 0 whenever valid=0. Both may be 1 on the same valid pulse.
REQ-020 valid SHALL pulse for every completed frame, including errored ones. data_out SHALL be updated even on error.
REQ-021 data_out SHALL hold its value between frames and change only on frame completion.
REQ-022 bit_en=0 SHALL freeze the FSM, the counter and the shift register. rx_in changes while bit_en=0 SHALL have no effect.
REQ-023 The block SHALL perform no glitch filtering and no start-bit revalidation; a 0 sampled in IDLE always starts a frame.
REQ-024 Back-to-back frames with no idle bits (stop followed immediately by start) SHALL be received without loss.

Reset
REQ-025 rst=1 SHALL immediately, without waiting for a clk edge, force state=IDLE, bit counter=0, shift register=0, data_out=0, valid=0, parity_err=0 and frame_err=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame with no valid pulse; after release the FSM SHALL wait in IDLE for a new start bit.
REQ-027 Outputs SHALL remain at their reset values for as long as rst=1, regardless of clk, bit_en and rx_in.

Verification
REQ-028 Good frame, even parity, bit_en=1 every cycle: the sequence 0, data 0xA5 LSB first (1,0,1,0,0,1,0,1), p=0, s=1 -> a single valid pulse with data_out=0xA5, parity_err=0, frame_err=0.
REQ-029 Parity error: the same frame with p=1 -> valid=1, data_out=0xA5, parity_err=1, frame_err=0. A further run with PARITY_ODD=1 and data 0x00, p=1 -> parity_err=0.
REQ-030 Framing error: data 0x3C, correct p=0, s=0 -> valid=1, data_out=0x3C, frame_err=1, parity_err=0.
REQ-031 Strobe spacing: bit_en=1 one cycle in every 4, with rx_in toggling randomly between strobes, frame for 0x81 -> data_out=0x81, valid exactly 1 cycle wide, no effect from the inter-strobe toggling.
REQ-032 Back-to-back: frames 0x12 then 0xEF with no idle bits -> two valid pulses 11 strobes apart, data_out=0x12 then 0xEF, no errors flagged.
REQ-033 Reset mid-frame: rst asserted asynchronously (between clk edges) after 4 data bits -> outputs go to 0 at once, no valid pulse; a following full frame 0x55 -> data_out=0x55 with valid=1.
